uart_flag_fifo: RTL and testbench

Parametrised multi-entry successor to the single-word UART flag buffer. It sits between the UART receiver (or the host write port) and the consumer. It absorbs bursts of `W`-bit words, exposes a "data available" flag and occupancy status, and detects overrun with a selectable drop-new or overwrite-oldest policy. It is used on both RX and TX sides of the UART.

---
 rtl/uart_flag_fifo_pkg.sv | 16 +
 rtl/uart_flag_fifo_mod_counter.sv | 26 ++
 rtl/uart_flag_fifo.sv | 126 ++++++++++++
 tb/tb_uart_flag_fifo.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uart_flag_fifo_pkg.sv
// Shared types and helpers for the UART flag FIFO: strobe decode and pointer sizing.
package uart_flag_fifo_pkg;

  // {push, pop} strobe pair as seen in one cycle
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } op_e;

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/uart_flag_fifo_mod_counter.sv
// Wrap-around modulo-MOD counter with enable; used for the FIFO read and write pointers.
module uart_flag_fifo_mod_counter
  import uart_flag_fifo_pkg::*;
#(
  parameter int MOD = 4,
  parameter int AW  = ptr_width(MOD)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_en,
  output logic [AW-1:0] o_q
);

  logic [AW-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= (r_q == AW'(MOD - 1)) ? '0 : r_q + AW'(1);
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_flag_fifo.sv
// Multi-entry UART flag buffer: FIFO with occupancy status and sticky overrun,
// selectable drop-new or overwrite-oldest behaviour when pushed while full.
module uart_flag_fifo
  import uart_flag_fifo_pkg::*;
#(
  parameter int W         = 8,
  parameter int DEPTH     = 4,
  parameter int AF_LEVEL  = DEPTH - 1,
  parameter int OVERWRITE = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   set_flag,
  input  logic [W-1:0]           din,
  input  logic                   clr_flag,
  input  logic                   clr_ovr,
  output logic [W-1:0]           dout,
  output logic                   flag,
  output logic                   full,
  output logic                   almost_full,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overrun
);

  localparam int AW = ptr_width(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF    = CW'(AF_LEVEL);

  logic [W-1:0]  r_mem [DEPTH];
  logic [CW-1:0] r_count;
  logic          r_overrun;

  logic [AW-1:0] w_wr_ptr;
  logic [AW-1:0] w_rd_ptr;
  logic          w_wr_en;
  logic          w_rd_en;
  logic          w_ovr_set;
  logic [CW-1:0] w_count_nxt;
  logic          w_overrun_nxt;
  logic          w_full;
  logic          w_nonempty;
  op_e           w_op;

  uart_flag_fifo_mod_counter #(.MOD(DEPTH), .AW(AW)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_wr_en),
    .o_q   (w_wr_ptr)
  );

  uart_flag_fifo_mod_counter #(.MOD(DEPTH), .AW(AW)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .i_en  (w_rd_en),
    .o_q   (w_rd_ptr)
  );

  assign w_full     = (r_count == C_DEPTH);
  assign w_nonempty = (r_count != '0);
  assign w_op       = op_e'({set_flag, clr_flag});

  always_comb begin
    w_wr_en     = 1'b0;
    w_rd_en     = 1'b0;
    w_ovr_set   = 1'b0;
    w_count_nxt = r_count;
    case (w_op)
      OP_PUSH: begin
        if (!w_full) begin
          w_wr_en     = 1'b1;
          w_count_nxt = r_count + CW'(1);
        end else begin
          w_ovr_set = 1'b1;
          // Overwrite mode evicts the head so the newest word always lands
          if (OVERWRITE != 0) begin
            w_wr_en = 1'b1;
            w_rd_en = 1'b1;
          end
        end
      end
      OP_POP: begin
        if (w_nonempty) begin
          w_rd_en     = 1'b1;
          w_count_nxt = r_count - CW'(1);
        end
      end
      OP_BOTH: begin
        w_wr_en = 1'b1;
        if (w_nonempty) begin
          w_rd_en = 1'b1;
        end else begin
          w_count_nxt = r_count + CW'(1);
        end
      end
      default: begin
      end
    endcase
    // A new overrun wins over a simultaneous clear
    w_overrun_nxt = w_ovr_set | (r_overrun & ~clr_ovr);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_count   <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_mem[w_wr_ptr] <= din;
      end
      r_count   <= w_count_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  assign dout        = r_mem[w_rd_ptr];
  assign flag        = w_nonempty;
  assign full        = w_full;
  assign almost_full = (r_count >= C_AF);
  assign count       = r_count;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_uart_flag_fifo.sv
// Bench for uart_flag_fifo: drop-new and overwrite-oldest instances share one stimulus
// stream; each is scored against its own queue model.
module tb_uart_flag_fifo;

  logic       clk = 1'b0;
  logic       reset;
  logic       set_flag;
  logic [7:0] din;
  logic       clr_flag;
  logic       clr_ovr;

  logic [7:0] dout0, dout1;
  logic       flag0, flag1, full0, full1, af0, af1, ovr0, ovr1;
  logic [2:0] count0, count1;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic       m_ovr0, m_ovr1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_flag_fifo #(.W(8), .DEPTH(4), .AF_LEVEL(3), .OVERWRITE(0)) u_drop (
    .clk(clk), .reset(reset), .set_flag(set_flag), .din(din), .clr_flag(clr_flag),
    .clr_ovr(clr_ovr), .dout(dout0), .flag(flag0), .full(full0), .almost_full(af0),
    .count(count0), .overrun(ovr0)
  );

  uart_flag_fifo #(.W(8), .DEPTH(4), .AF_LEVEL(3), .OVERWRITE(1)) u_ovw (
    .clk(clk), .reset(reset), .set_flag(set_flag), .din(din), .clr_flag(clr_flag),
    .clr_ovr(clr_ovr), .dout(dout1), .flag(flag1), .full(full1), .almost_full(af1),
    .count(count1), .overrun(ovr1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_status(input string tag);
    check({tag, ".count0"}, 32'(count0), 32'(q0.size()));
    check({tag, ".count1"}, 32'(count1), 32'(q1.size()));
    check({tag, ".flag0"},  32'(flag0),  32'(q0.size() != 0));
    check({tag, ".flag1"},  32'(flag1),  32'(q1.size() != 0));
    check({tag, ".full0"},  32'(full0),  32'(q0.size() == 4));
    check({tag, ".full1"},  32'(full1),  32'(q1.size() == 4));
    check({tag, ".af0"},    32'(af0),    32'(q0.size() >= 3));
    check({tag, ".af1"},    32'(af1),    32'(q1.size() >= 3));
    check({tag, ".ovr0"},   32'(ovr0),   32'(m_ovr0));
    check({tag, ".ovr1"},   32'(ovr1),   32'(m_ovr1));
    if (q0.size() != 0) check({tag, ".head0"}, 32'(dout0), 32'(q0[0]));
    if (q1.size() != 0) check({tag, ".head1"}, 32'(dout1), 32'(q1[0]));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".dout0"},  32'(dout0),  32'h0);
    check({tag, ".dout1"},  32'(dout1),  32'h0);
    check({tag, ".flag0"},  32'(flag0),  32'h0);
    check({tag, ".flag1"},  32'(flag1),  32'h0);
    check({tag, ".full0"},  32'(full0),  32'h0);
    check({tag, ".af0"},    32'(af0),    32'h0);
    check({tag, ".count0"}, 32'(count0), 32'h0);
    check({tag, ".count1"}, 32'(count1), 32'h0);
    check({tag, ".ovr0"},   32'(ovr0),   32'h0);
    check({tag, ".ovr1"},   32'(ovr1),   32'h0);
  endtask

  // Reference behaviour of one FIFO for one cycle of strobes
  task automatic model_step(inout logic [7:0] q[$], inout logic ovr, input bit ovw,
                            input logic push, input logic [7:0] d, input logic pop,
                            input logic clr);
    logic set_ovr;
    logic [7:0] tmp;
    set_ovr = 1'b0;
    if (push && pop) begin
      if (q.size() != 0) tmp = q.pop_front();
      q.push_back(d);
    end else if (push) begin
      if (q.size() < 4) begin
        q.push_back(d);
      end else begin
        set_ovr = 1'b1;
        if (ovw) begin
          tmp = q.pop_front();
          q.push_back(d);
        end
      end
    end else if (pop && q.size() != 0) begin
      tmp = q.pop_front();
    end
    if (set_ovr) ovr = 1'b1;
    else if (clr) ovr = 1'b0;
  endtask

  task automatic cycle(input string tag, input logic push, input logic [7:0] d,
                       input logic pop, input logic clr);
    @(negedge clk);
    set_flag = push;
    din      = d;
    clr_flag = pop;
    clr_ovr  = clr;
    if (pop && q0.size() != 0) check({tag, ".pop0"}, 32'(dout0), 32'(q0[0]));
    if (pop && q1.size() != 0) check({tag, ".pop1"}, 32'(dout1), 32'(q1[0]));
    model_step(q0, m_ovr0, 1'b0, push, d, pop, clr);
    model_step(q1, m_ovr1, 1'b1, push, d, pop, clr);
    @(posedge clk);
    #1;
    set_flag = 1'b0;
    clr_flag = 1'b0;
    clr_ovr  = 1'b0;
    check_status(tag);
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    m_ovr0 = 1'b0;
    m_ovr1 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; set_flag = 1'b0; din = '0; clr_flag = 1'b0; clr_ovr = 1'b0;
    clear_model();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b0;

    cycle("push_a5", 1'b1, 8'hA5, 1'b0, 1'b0);
    check("a5.dout", 32'(dout0), 32'hA5);
    cycle("pop_a5", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("pop_empty", 1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 1; i <= 4; i++) cycle("fill", 1'b1, 8'(i), 1'b0, 1'b0);
    check("fill.full", 32'(full0), 32'h1);
    cycle("ovr_push", 1'b1, 8'h55, 1'b0, 1'b0);
    check("ovw.head", 32'(dout1), 32'h02);
    cycle("clr_ovr", 1'b0, 8'h00, 1'b0, 1'b1);
    cycle("ovr_push2", 1'b1, 8'h66, 1'b0, 1'b1);
    cycle("clr_ovr2", 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);

    cycle("pp_empty", 1'b1, 8'h11, 1'b1, 1'b0);
    cycle("half", 1'b1, 8'h22, 1'b0, 1'b0);
    cycle("pp_half", 1'b1, 8'h33, 1'b1, 1'b0);
    cycle("to_full", 1'b1, 8'h44, 1'b0, 1'b0);
    cycle("to_full", 1'b1, 8'h77, 1'b0, 1'b0);
    cycle("pp_full", 1'b1, 8'h88, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cycle("drain2", 1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      cycle("wrap_push", 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      if (i % 2 == 1) cycle("wrap_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    end

    for (int i = 0; i < 60; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) == 0));
    end

    cycle("pre_rst", 1'b1, 8'h9C, 1'b0, 1'b0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    clear_model();
    check_reset_outputs("async_rst");
    @(negedge clk);
    reset = 1'b0;
    cycle("post_rst", 1'b1, 8'h3C, 1'b0, 1'b0);
    cycle("post_rst_pop", 1'b0, 8'h00, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
